wallace_mult_pipe: RTL

//  Parametrised, pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready handshake.

---
 rtl/wallace_pkg.sv | 46 ++++
 rtl/wallace_csa_tree.sv | 83 ++++++++
 rtl/wallace_mult_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/wallace_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier:
// pipeline depth, operation-mode encoding and elaboration-time helpers
// that size the carry-save reduction tree.
package wallace_pkg;

  // Number of register stages between an accepted input and out_valid.
  localparam int LATENCY = 3;

  // Operation mode carried with every transaction.
  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  // Rows entering the tree: one partial product per multiplier bit plus
  // one correction-constant row (all zero in unsigned mode).
  function automatic int pp_count(input int width);
    return width + 32'sd1;
  endfunction

  // Rows left after 'levels' layers of 3:2 compression starting from n rows.
  // Each full group of three rows becomes a sum and a carry row; leftover
  // rows pass straight through to the next layer.
  function automatic int rows_after(input int n, input int levels);
    int r;
    r = n;
    for (int i = 0; i < levels; i++) begin
      r = (r / 32'sd3) * 32'sd2 + (r % 32'sd3);
    end
    return r;
  endfunction

  // Number of compression layers needed to bring n rows down to two.
  function automatic int csa_levels(input int n);
    int r;
    int cnt;
    r   = n;
    cnt = 32'sd0;
    while (r > 32'sd2) begin
      r   = (r / 32'sd3) * 32'sd2 + (r % 32'sd3);
      cnt = cnt + 32'sd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wallace_csa_tree.sv
// Combinational partial-product generation and carry-save reduction.
// Produces two 2*WIDTH rows (sum, carry) whose modular sum is a*b, for
// either unsigned or two's-complement (Baugh-Wooley) operands.
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] sum,
  output logic [2*WIDTH-1:0] carry
);

  localparam int PW    = 2 * WIDTH;
  localparam int NROWS = pp_count(WIDTH);
  localparam int NLEV  = csa_levels(NROWS);

  // Bits that Baugh-Wooley inverts: the a-MSB term in ordinary rows, and
  // every term except the a-MSB one in the row for the b-MSB.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LOW_MASK = ~MSB_MASK;

  // Signed correction constant: +1 at column WIDTH and column 2*WIDTH-1.
  localparam logic [PW-1:0] ONE_ROW   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] CONST_ROW = (ONE_ROW << WIDTH) | (ONE_ROW << (PW - 1));

  // Row-wide full adder: bitwise sum of three rows.
  function automatic logic [PW-1:0] fa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                           input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Row-wide full adder carry, moved up one column; the carry out of the
  // top column falls off because the product is taken mod 2^(2*WIDTH).
  function automatic logic [PW-1:0] fa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                             input logic [PW-1:0] z);
    logic [PW-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PW-2:0], 1'b0};
  endfunction

  // lvl_s[k] holds the rows after k compression layers.
  logic [PW-1:0] lvl_s [0:NLEV][0:NROWS-1];

  // Partial-product rows, each widened to the full product width and
  // shifted to its column.
  for (genvar j = 0; j < WIDTH; j++) begin : g_pp
    localparam logic [WIDTH-1:0] INV_MASK = (j == WIDTH - 1) ? LOW_MASK : MSB_MASK;
    logic [WIDTH-1:0] raw_s;
    assign raw_s         = (a & {WIDTH{b[j]}}) ^ (INV_MASK & {WIDTH{is_signed}});
    assign lvl_s[0][j]   = {{WIDTH{1'b0}}, raw_s} << j;
  end

  assign lvl_s[0][NROWS-1] = is_signed ? CONST_ROW : {PW{1'b0}};

  // Compression layers: group rows in threes, pass leftovers through,
  // tie the unused slots of each layer to zero.
  for (genvar lv = 0; lv < NLEV; lv++) begin : g_lvl
    localparam int CUR = rows_after(NROWS, lv);
    localparam int GRP = CUR / 3;
    localparam int REM = CUR % 3;
    for (genvar r = 0; r < NROWS; r++) begin : g_row
      if (r < 2 * GRP) begin : g_fa
        localparam int G = r / 2;
        if (r % 2 == 0) begin : g_s
          assign lvl_s[lv+1][r] = fa_sum(lvl_s[lv][3*G], lvl_s[lv][3*G+1], lvl_s[lv][3*G+2]);
        end else begin : g_c
          assign lvl_s[lv+1][r] = fa_carry(lvl_s[lv][3*G], lvl_s[lv][3*G+1], lvl_s[lv][3*G+2]);
        end
      end else if (r < 2 * GRP + REM) begin : g_pass
        assign lvl_s[lv+1][r] = lvl_s[lv][3*GRP + (r - 2*GRP)];
      end else begin : g_zero
        assign lvl_s[lv+1][r] = {PW{1'b0}};
      end
    end
  end

  assign sum   = lvl_s[NLEV][0];
  assign carry = lvl_s[NLEV][1];

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with valid/ready on both
// sides. S1 registers the operands, S2 registers the carry-save rows, S3
// registers the final carry-propagate sum. One global advance signal
// freezes every stage while the consumer back-pressures.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    mult_mode_e       mode;
    logic [TAG_W-1:0] tag;
  } s1_payload_t;

  logic             adv_s;
  logic             s1_valid_r;
  s1_payload_t      s1_r;
  logic [PW-1:0]    tree_sum_s;
  logic [PW-1:0]    tree_carry_s;
  logic             s2_valid_r;
  logic [PW-1:0]    s2_sum_r;
  logic [PW-1:0]    s2_carry_r;
  logic [TAG_W-1:0] s2_tag_r;

  // The whole pipe moves unless a presented result is being refused.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // S1: capture operands, mode and tag on an input transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_r <= '{a: in_a, b: in_b, mode: mult_mode_e'(in_signed), tag: in_tag};
      end
    end
  end

  wallace_csa_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .a         (s1_r.a),
    .b         (s1_r.b),
    .is_signed (s1_r.mode == MODE_SIGNED),
    .sum       (tree_sum_s),
    .carry     (tree_carry_s)
  );

  // S2: register the reduced sum/carry rows and the tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_carry_r <= '0;
      s2_tag_r   <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sum_r   <= tree_sum_s;
        s2_carry_r <= tree_carry_s;
        s2_tag_r   <= s1_r.tag;
      end
    end
  end

  // S3: final carry-propagate add into the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_product <= s2_sum_r + s2_carry_r;
        out_tag     <= s2_tag_r;
      end
    end
  end

endmodule
